// File: rtl/bus_cycle_pkg.sv
// Shared definitions for the bus cycle sequencer: phase numbers, FSM states
// and the bounded one-hot decoder used for chip drive enables.
package bus_cycle_pkg;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cycle_state_t;

  // A chip index beyond the populated range selects nobody, so the bus floats.
  function automatic logic [15:0] onehot_sel(input logic [3:0] index, input logic [4:0] limit);
    logic [15:0] v;
    v = '0;
    if ({1'b0, index} < limit) v[index] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cycle_phase_counter.sv
// IDLE/RUN state machine stepping the eight bus phases; exposes the next
// phase so the top can register its decodes in step with the phase itself.
module cycle_phase_counter
  import bus_cycle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_run,
  output logic [2:0] o_phase,
  output logic       o_active,
  output logic       o_sync,
  output logic [2:0] o_nextPhase,
  output logic       o_nextActive
);

  cycle_state_t r_state;
  cycle_state_t w_stateNext;
  logic [2:0]   r_phase;
  logic [2:0]   w_phaseNext;
  logic         r_sync;

  // run is only looked at while idle or at X3, so a started cycle always finishes.
  always_comb begin
    w_stateNext = r_state;
    w_phaseNext = PH_A1;
    case (r_state)
      ST_IDLE: begin
        if (i_run) w_stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (r_phase == PH_X3) begin
          w_stateNext = i_run ? ST_RUN : ST_IDLE;
        end else begin
          w_phaseNext = r_phase + 3'd1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
    if (reset) begin
      w_stateNext = ST_IDLE;
      w_phaseNext = PH_A1;
    end
  end

  always_ff @(posedge clock) begin
    r_state <= w_stateNext;
    r_phase <= w_phaseNext;
    r_sync  <= (w_stateNext == ST_RUN) && (w_phaseNext == PH_X3);
  end

  assign o_phase      = r_phase;
  assign o_active     = (r_state == ST_RUN);
  assign o_sync       = r_sync;
  assign o_nextPhase  = w_phaseNext;
  assign o_nextActive = (w_stateNext == ST_RUN);

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Bus cycle sequencer: phase timing, chip-select latches, command strobes and
// arbitration of the shared 4-bit data bus between CPU, ROM and RAM.
module bus_cycle_sequencer
  import bus_cycle_pkg::*;
#(
  parameter int NUM_ROMS = 2,
  parameter int NUM_RAMS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_run,
  input  logic [3:0]          i_bus_in,
  input  logic                i_cpu_io_op,
  input  logic                i_cpu_io_read,
  input  logic                i_cpu_io_rom,
  input  logic                i_cpu_src,
  output logic [2:0]          o_phase,
  output logic                o_active,
  output logic                o_sync,
  output logic                o_cm_rom,
  output logic                o_cm_ram,
  output logic                o_cpu_drive,
  output logic [NUM_ROMS-1:0] o_rom_drive,
  output logic [NUM_RAMS-1:0] o_ram_drive,
  output logic [3:0]          o_rom_sel,
  output logic [3:0]          o_src_sel
);

  logic [2:0]          w_phase;
  logic                w_active;
  logic [2:0]          w_nextPhase;
  logic                w_nextActive;
  logic [3:0]          w_romSelNext;
  logic                w_cpuDriveNext;
  logic [NUM_ROMS-1:0] w_romDriveNext;
  logic [NUM_RAMS-1:0] w_ramDriveNext;
  logic                w_cmNext;

  logic [3:0]          r_romSel;
  logic [3:0]          r_srcSel;
  logic                r_flagSrc;
  logic                r_flagIoOp;
  logic                r_flagIoRead;
  logic                r_flagIoRom;
  logic                r_cpuDrive;
  logic [NUM_ROMS-1:0] r_romDrive;
  logic [NUM_RAMS-1:0] r_ramDrive;
  logic                r_cm;

  cycle_phase_counter u_counter (
    .clock        (clock),
    .reset        (reset),
    .i_run        (i_run),
    .o_phase      (w_phase),
    .o_active     (w_active),
    .o_sync       (o_sync),
    .o_nextPhase  (w_nextPhase),
    .o_nextActive (w_nextActive)
  );

  // M1 is decoded on the same edge that captures the high address nibble.
  assign w_romSelNext = (w_active && (w_phase == PH_A3)) ? i_bus_in : r_romSel;

  always_comb begin
    w_cpuDriveNext = 1'b0;
    w_romDriveNext = '0;
    w_ramDriveNext = '0;
    w_cmNext       = 1'b0;
    if (w_nextActive) begin
      case (w_nextPhase)
        PH_A1, PH_A2: w_cpuDriveNext = 1'b1;
        PH_A3: begin
          w_cpuDriveNext = 1'b1;
          w_cmNext       = 1'b1;
        end
        PH_M1: w_romDriveNext = NUM_ROMS'(onehot_sel(w_romSelNext, 5'(NUM_ROMS)));
        PH_M2: begin
          w_romDriveNext = NUM_ROMS'(onehot_sel(w_romSelNext, 5'(NUM_ROMS)));
          w_cmNext       = i_cpu_io_op;
        end
        PH_X2: begin
          if (r_flagSrc) begin
            w_cpuDriveNext = 1'b1;
            w_cmNext       = 1'b1;
          end else if (r_flagIoOp && r_flagIoRead && r_flagIoRom) begin
            w_romDriveNext = NUM_ROMS'(onehot_sel(r_srcSel, 5'(NUM_ROMS)));
          end else if (r_flagIoOp && r_flagIoRead) begin
            w_ramDriveNext = NUM_RAMS'(onehot_sel({2'b00, r_srcSel[3:2]}, 5'(NUM_RAMS)));
          end else if (r_flagIoOp) begin
            w_cpuDriveNext = 1'b1;
          end
        end
        PH_X3: w_cpuDriveNext = r_flagSrc;
        default: w_cpuDriveNext = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_romSel     <= 4'h0;
      r_srcSel     <= 4'h0;
      r_flagSrc    <= 1'b0;
      r_flagIoOp   <= 1'b0;
      r_flagIoRead <= 1'b0;
      r_flagIoRom  <= 1'b0;
      r_cpuDrive   <= 1'b0;
      r_romDrive   <= '0;
      r_ramDrive   <= '0;
      r_cm         <= 1'b0;
    end else begin
      r_romSel <= w_romSelNext;
      if (w_active && (w_phase == PH_X2) && r_flagSrc) r_srcSel <= i_bus_in;
      if (w_active && (w_phase == PH_M2)) begin
        r_flagSrc    <= i_cpu_src;
        r_flagIoOp   <= i_cpu_io_op;
        r_flagIoRead <= i_cpu_io_read;
        r_flagIoRom  <= i_cpu_io_rom;
      end
      r_cpuDrive <= w_cpuDriveNext;
      r_romDrive <= w_romDriveNext;
      r_ramDrive <= w_ramDriveNext;
      r_cm       <= w_cmNext;
    end
  end

  assign o_phase     = w_phase;
  assign o_active    = w_active;
  assign o_cm_rom    = r_cm;
  assign o_cm_ram    = r_cm;
  assign o_cpu_drive = r_cpuDrive;
  assign o_rom_drive = r_romDrive;
  assign o_ram_drive = r_ramDrive;
  assign o_rom_sel   = r_romSel;
  assign o_src_sel   = r_srcSel;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: literal vector table, hand-written corner
// sequences and randomized traffic, all checked against a phase-level model.
module tb_bus_cycle_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, run, ioOp, ioRead, ioRom, cpuSrc;
  logic [3:0] busIn;
  logic [2:0] o_phase;
  logic       o_active, o_sync, o_cm_rom, o_cm_ram, o_cpu_drive;
  logic [1:0] o_rom_drive, o_ram_drive;
  logic [3:0] o_rom_sel, o_src_sel;

  bus_cycle_sequencer #(.NUM_ROMS(2), .NUM_RAMS(2)) dut (
    .clock(clock), .reset(reset), .i_run(run), .i_bus_in(busIn),
    .i_cpu_io_op(ioOp), .i_cpu_io_read(ioRead), .i_cpu_io_rom(ioRom), .i_cpu_src(cpuSrc),
    .o_phase(o_phase), .o_active(o_active), .o_sync(o_sync),
    .o_cm_rom(o_cm_rom), .o_cm_ram(o_cm_ram), .o_cpu_drive(o_cpu_drive),
    .o_rom_drive(o_rom_drive), .o_ram_drive(o_ram_drive),
    .o_rom_sel(o_rom_sel), .o_src_sel(o_src_sel)
  );

  typedef struct {
    logic       rst, rn;
    logic [3:0] bus;
    logic [2:0] ph;
    logic       act, sync, cm, cpu;
    logic [1:0] romD, ramD;
    logic [3:0] romSel;
  } vec_t;

  vec_t vecs[$];
  int   vecCount = 0;
  int   missCount = 0;

  // Model: mPhase is -1 while idle, otherwise 0..7; flags are the M2 snapshot.
  int mPhase = -1, mRomSel = 0, mSrcSel = 0;
  bit mSrc, mIo, mRd, mRom, mM1Io;

  logic [1:0] snapX2Rom, snapX2Ram;
  logic       snapM2Cm, snapX2Cm, snapX2Cpu, snapX3Cpu;

  function automatic vec_t mkv(logic rst, logic rn, logic [3:0] bus, logic [2:0] ph, logic act,
                               logic sync, logic cm, logic cpu, logic [1:0] romD, logic [1:0] ramD,
                               logic [3:0] romSel);
    vec_t v;
    v.rst = rst; v.rn = rn; v.bus = bus; v.ph = ph; v.act = act; v.sync = sync;
    v.cm = cm; v.cpu = cpu; v.romD = romD; v.ramD = ramD; v.romSel = romSel;
    return v;
  endfunction

  function automatic void modelStep();
    int old;
    if (reset) begin
      mPhase = -1; mRomSel = 0; mSrcSel = 0;
      mSrc = 0; mIo = 0; mRd = 0; mRom = 0; mM1Io = 0;
    end else begin
      old = mPhase;
      if (old == 2) mRomSel = int'(busIn);
      if (old == 6 && mSrc) mSrcSel = int'(busIn);
      if (old == 3) mM1Io = ioOp;
      if (old == 4) begin
        mSrc = cpuSrc; mIo = ioOp; mRd = ioRead; mRom = ioRom;
      end
      mPhase = (old < 0 || old == 7) ? (run ? 0 : -1) : old + 1;
    end
  endfunction

  task automatic checkVal(input string name, input int got, input int exp);
    vecCount++;
    if (got != exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic checkOutput();
    bit         act, eSync, eCm, eCpu, ioRd;
    int         ph;
    logic [1:0] eRom, eRam;
    act  = (mPhase >= 0);
    ph   = act ? mPhase : 0;
    ioRd = !mSrc && mIo && mRd;
    eSync = act && ph == 7;
    eCpu  = act && (ph <= 2 || (ph == 6 && (mSrc || (mIo && !mRd))) || (ph == 7 && mSrc));
    eCm   = act && (ph == 2 || (ph == 4 && mM1Io) || (ph == 6 && mSrc));
    eRom  = 2'b00;
    eRam  = 2'b00;
    if (act && (ph == 3 || ph == 4) && mRomSel < 2) eRom = 2'(1 << mRomSel);
    if (act && ph == 6 && ioRd && mRom && mSrcSel < 2) eRom = 2'(1 << mSrcSel);
    if (act && ph == 6 && ioRd && !mRom && (mSrcSel / 4) < 2) eRam = 2'(1 << (mSrcSel / 4));
    vecCount++;
    if (o_phase != 3'(ph) || o_active != act || o_sync != eSync || o_cm_rom != eCm ||
        o_cm_ram != eCm || o_cpu_drive != eCpu || o_rom_drive != eRom || o_ram_drive != eRam ||
        o_rom_sel != 4'(mRomSel) || o_src_sel != 4'(mSrcSel)) begin
      missCount++;
      $display("[TB] FAIL model@%0t: got ph=%0d act=%b sync=%b cm=%b/%b cpu=%b rom=%b ram=%b rs=%h ss=%h, expected ph=%0d act=%b sync=%b cm=%b cpu=%b rom=%b ram=%b rs=%h ss=%h",
               $time, o_phase, o_active, o_sync, o_cm_rom, o_cm_ram, o_cpu_drive, o_rom_drive,
               o_ram_drive, o_rom_sel, o_src_sel, ph, act, eSync, eCm, eCpu, eRom, eRam,
               4'(mRomSel), 4'(mSrcSel));
    end
    checkVal("one_driver", ($countones({o_cpu_drive, |o_rom_drive, |o_ram_drive}) <= 1) ? 1 : 0, 1);
  endtask

  task automatic applyStimulus(input logic rst, input logic rn, input logic [3:0] bus,
                               input logic io, input logic rd, input logic rm, input logic sr);
    reset = rst; run = rn; busIn = bus; ioOp = io; ioRead = rd; ioRom = rm; cpuSrc = sr;
    @(posedge clock);
    modelStep();
    #1;
    checkOutput();
    if (o_active && o_phase == 3'd4) snapM2Cm = o_cm_rom;
    if (o_active && o_phase == 3'd6) begin
      snapX2Rom = o_rom_drive; snapX2Ram = o_ram_drive; snapX2Cm = o_cm_rom; snapX2Cpu = o_cpu_drive;
    end
    if (o_active && o_phase == 3'd7) snapX3Cpu = o_cpu_drive;
  endtask

  // One full cycle from X3 or idle; busA3 is captured as rom_sel, busX2 as src_sel.
  task automatic doCycle(input logic [3:0] busA3, input logic [3:0] busX2,
                         input logic io, input logic rd, input logic rm, input logic sr);
    snapM2Cm = 0; snapX2Cm = 0; snapX2Cpu = 0; snapX3Cpu = 0; snapX2Rom = 0; snapX2Ram = 0;
    for (int s = 0; s < 8; s++)
      applyStimulus(1'b0, 1'b1, (s == 3) ? busA3 : ((s == 7) ? busX2 : 4'h0), io, rd, rm, sr);
  endtask

  initial begin
    logic rIo, rRd, rRm, rSr;
    reset = 1; run = 0; busIn = 0; ioOp = 0; ioRead = 0; ioRom = 0; cpuSrc = 0;
    rIo = 0; rRd = 0; rRm = 0; rSr = 0;

    //            rst run bus   ph    act sy cm cpu rom    ram    romSel
    vecs.push_back(mkv(1, 0, 4'h0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0));
    vecs.push_back(mkv(1, 0, 4'h0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0));
    for (int c = 0; c < 2; c++) begin
      vecs.push_back(mkv(0, 1, 4'h0, 3'd0, 1, 0, 0, 1, 2'b00, 2'b00, 4'h0));
      vecs.push_back(mkv(0, 1, 4'h0, 3'd1, 1, 0, 0, 1, 2'b00, 2'b00, 4'h0));
      vecs.push_back(mkv(0, 1, 4'h0, 3'd2, 1, 0, 1, 1, 2'b00, 2'b00, 4'h0));
      vecs.push_back(mkv(0, 1, 4'h0, 3'd3, 1, 0, 0, 0, 2'b01, 2'b00, 4'h0));
      vecs.push_back(mkv(0, 1, 4'h0, 3'd4, 1, 0, 0, 0, 2'b01, 2'b00, 4'h0));
      vecs.push_back(mkv(0, 1, 4'h0, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00, 4'h0));
      vecs.push_back(mkv(0, 1, 4'h0, 3'd6, 1, 0, 0, 0, 2'b00, 2'b00, 4'h0));
      vecs.push_back(mkv(0, 1, 4'h0, 3'd7, 1, 1, 0, 0, 2'b00, 2'b00, 4'h0));
    end
    vecs.push_back(mkv(0, 1, 4'h1, 3'd0, 1, 0, 0, 1, 2'b00, 2'b00, 4'h0));
    vecs.push_back(mkv(0, 1, 4'h1, 3'd1, 1, 0, 0, 1, 2'b00, 2'b00, 4'h0));
    vecs.push_back(mkv(0, 1, 4'h1, 3'd2, 1, 0, 1, 1, 2'b00, 2'b00, 4'h0));
    vecs.push_back(mkv(0, 1, 4'h1, 3'd3, 1, 0, 0, 0, 2'b10, 2'b00, 4'h1));
    vecs.push_back(mkv(0, 1, 4'h1, 3'd4, 1, 0, 0, 0, 2'b10, 2'b00, 4'h1));
    vecs.push_back(mkv(0, 1, 4'h1, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00, 4'h1));
    vecs.push_back(mkv(0, 1, 4'h1, 3'd6, 1, 0, 0, 0, 2'b00, 2'b00, 4'h1));
    vecs.push_back(mkv(0, 1, 4'h1, 3'd7, 1, 1, 0, 0, 2'b00, 2'b00, 4'h1));
    vecs.push_back(mkv(0, 1, 4'h5, 3'd0, 1, 0, 0, 1, 2'b00, 2'b00, 4'h1));
    vecs.push_back(mkv(0, 1, 4'h5, 3'd1, 1, 0, 0, 1, 2'b00, 2'b00, 4'h1));
    vecs.push_back(mkv(0, 1, 4'h5, 3'd2, 1, 0, 1, 1, 2'b00, 2'b00, 4'h1));
    vecs.push_back(mkv(0, 1, 4'h5, 3'd3, 1, 0, 0, 0, 2'b00, 2'b00, 4'h5));
    vecs.push_back(mkv(0, 1, 4'h5, 3'd4, 1, 0, 0, 0, 2'b00, 2'b00, 4'h5));
    vecs.push_back(mkv(0, 1, 4'h5, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00, 4'h5));
    vecs.push_back(mkv(0, 1, 4'h5, 3'd6, 1, 0, 0, 0, 2'b00, 2'b00, 4'h5));
    vecs.push_back(mkv(0, 1, 4'h5, 3'd7, 1, 1, 0, 0, 2'b00, 2'b00, 4'h5));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rn, vecs[i].bus, 1'b0, 1'b0, 1'b0, 1'b0);
      vecCount++;
      if (o_phase != vecs[i].ph || o_active != vecs[i].act || o_sync != vecs[i].sync ||
          o_cm_rom != vecs[i].cm || o_cm_ram != vecs[i].cm || o_cpu_drive != vecs[i].cpu ||
          o_rom_drive != vecs[i].romD || o_ram_drive != vecs[i].ramD || o_rom_sel != vecs[i].romSel) begin
        missCount++;
        $display("[TB] FAIL table[%0d]: got ph=%0d act=%b sync=%b cm=%b/%b cpu=%b rom=%b ram=%b rs=%h, expected ph=%0d act=%b sync=%b cm=%b cpu=%b rom=%b ram=%b rs=%h",
                 i, o_phase, o_active, o_sync, o_cm_rom, o_cm_ram, o_cpu_drive, o_rom_drive,
                 o_ram_drive, o_rom_sel, vecs[i].ph, vecs[i].act, vecs[i].sync, vecs[i].cm,
                 vecs[i].cpu, vecs[i].romD, vecs[i].ramD, vecs[i].romSel);
      end
    end

    doCycle(4'h0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("src_x2_cm", int'(snapX2Cm), 1);
    checkVal("src_x2_cpu", int'(snapX2Cpu), 1);
    checkVal("src_x3_cpu", int'(snapX3Cpu), 1);
    checkVal("src_sel_6", int'(o_src_sel), 6);
    doCycle(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("ram_read_x2", int'(snapX2Ram), 2);
    checkVal("ram_read_m2_cm", int'(snapM2Cm), 1);
    doCycle(4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    doCycle(4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkVal("rom_read_x2", int'(snapX2Rom), 2);
    checkVal("rom_read_no_ram", int'(snapX2Ram), 0);

    for (int s = 0; s < 8; s++) applyStimulus(1'b0, (s < 4), 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("drop_completes_x3", int'(o_phase), 7);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("drop_idle_active", int'(o_active), 0);
    checkVal("drop_idle_phase", int'(o_phase), 0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("restart_active", int'(o_active), 1);
    checkVal("restart_phase", int'(o_phase), 0);
    for (int s = 1; s < 8; s++) applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    doCycle(4'h0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 7; s++) applyStimulus(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("reset_mid_active", int'(o_active), 0);
    checkVal("reset_mid_src_sel", int'(o_src_sel), 0);
    checkVal("reset_mid_drives", int'({o_cpu_drive, o_rom_drive, o_ram_drive}), 0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if (mPhase < 0 || mPhase == 7) begin
        rIo = 1'($urandom); rRd = 1'($urandom); rRm = 1'($urandom); rSr = ($urandom_range(0, 3) == 0);
      end
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    4'($urandom_range(0, 15)), rIo, rRd, rRm, rSr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
